// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: sequences each instruction through IF/ID/EXE/MEM/WB
// and decodes the PC, IR, register-file, ALU and data-memory controls.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t state_q, state_d;

  logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
  logic is_sw, is_lw, is_beq, is_j, is_jr, is_jal, is_halt;
  logic is_rtype, is_defined, is_jump;

  assign is_add  = (opcode == OP_ADD);
  assign is_sub  = (opcode == OP_SUB);
  assign is_addi = (opcode == OP_ADDI);
  assign is_or   = (opcode == OP_OR);
  assign is_and  = (opcode == OP_AND);
  assign is_ori  = (opcode == OP_ORI);
  assign is_sll  = (opcode == OP_SLL);
  assign is_slt  = (opcode == OP_SLT);
  assign is_sw   = (opcode == OP_SW);
  assign is_lw   = (opcode == OP_LW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_jr   = (opcode == OP_JR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_halt = (opcode == OP_HALT);

  assign is_rtype   = is_add | is_sub | is_or | is_and | is_sll | is_slt;
  assign is_defined = is_rtype | is_addi | is_ori | is_sw | is_lw | is_beq |
                      is_j | is_jr | is_jal | is_halt;
  // Undefined opcodes retire in ID like a jump with PCSrc=00, i.e. a no-op.
  assign is_jump    = is_j | is_jr | is_jal | ~is_defined;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_jump)             state_d = S_IF;
        else if (is_halt)        state_d = S_ID;
        else if (is_beq)         state_d = S_EXE_BR;
        else if (is_sw || is_lw) state_d = S_EXE_LS;
        else                     state_d = S_EXE_AL;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  logic       pcwre_raw, irwre_raw, regwre_raw, mrd_raw, mwr_raw;
  logic [1:0] pcsrc_raw, regdst_raw;
  logic       wrsrc_raw;

  always_comb begin
    pcwre_raw  = 1'b0;
    irwre_raw  = 1'b0;
    regwre_raw = 1'b0;
    mrd_raw    = 1'b0;
    mwr_raw    = 1'b0;
    pcsrc_raw  = 2'b00;
    regdst_raw = 2'b00;
    wrsrc_raw  = 1'b0;
    case (state_q)
      S_IF: irwre_raw = 1'b1;
      S_ID: begin
        pcwre_raw = is_jump;
        if (is_j || is_jal) pcsrc_raw = 2'b11;
        else if (is_jr)     pcsrc_raw = 2'b10;
        if (is_jal) begin
          regwre_raw = 1'b1;
          regdst_raw = 2'b00;
          wrsrc_raw  = 1'b0;
        end
      end
      S_EXE_BR: begin
        pcwre_raw = 1'b1;
        pcsrc_raw = zero ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        pcwre_raw = is_sw;
        mrd_raw   = is_lw;
        mwr_raw   = is_sw;
      end
      S_WB_LD: begin
        pcwre_raw  = 1'b1;
        regwre_raw = 1'b1;
        regdst_raw = 2'b01;
        wrsrc_raw  = 1'b1;
      end
      S_WB_AL: begin
        pcwre_raw  = 1'b1;
        regwre_raw = 1'b1;
        regdst_raw = is_rtype ? 2'b10 : 2'b01;
        wrsrc_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces IF, but IF must not load the IR until reset is released.
  assign PCWre     = pcwre_raw  & ~reset;
  assign IRWre     = irwre_raw  & ~reset;
  assign RegWre    = regwre_raw & ~reset;
  assign mRD       = mrd_raw    & ~reset;
  assign mWR       = mwr_raw    & ~reset;
  assign PCSrc     = reset ? 2'b00 : pcsrc_raw;
  assign RegDst    = reset ? 2'b00 : regdst_raw;
  assign WrRegDSrc = wrsrc_raw & ~reset;

  always_comb begin
    ALUOp = 3'b000;
    if (is_sub || is_beq)     ALUOp = 3'b001;
    else if (is_sll)          ALUOp = 3'b010;
    else if (is_or || is_ori) ALUOp = 3'b011;
    else if (is_and)          ALUOp = 3'b100;
    else if (is_slt)          ALUOp = 3'b101;
  end

  assign ALUSrcA   = is_sll;
  assign ALUSrcB   = is_addi | is_ori | is_lw | is_sw;
  assign ExtSel    = ~is_ori;
  assign DBDataSrc = is_lw;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state paths and control rules
// predicted from the opcode class, compared every cycle on the falling edge.
module tb_multicycle_ctrl;

  localparam int W = 20;

  localparam logic [5:0] ADD  = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_  = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLL  = 6'b011000, SLT = 6'b100110, SW = 6'b110000;
  localparam logic [5:0] LW   = 6'b110001, BEQ = 6'b110100, J = 6'b111000;
  localparam logic [5:0] JR   = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  localparam int C_JMP = 0, C_HALT = 1, C_BR = 2, C_SW = 3, C_LW = 4, C_R = 5, C_I = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = ADD;
  logic       zero = 1'b0;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc, ExtSel, mRD, mWR;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .state(state)
  );

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      ADD, SUB, OR_, AND_, SLL, SLT: return C_R;
      ADDI, ORI: return C_I;
      SW:   return C_SW;
      LW:   return C_LW;
      BEQ:  return C_BR;
      HALT: return C_HALT;
      default: return C_JMP;
    endcase
  endfunction

  function automatic logic is_def(input logic [5:0] op);
    return (cls_of(op) != C_JMP) || op == J || op == JR || op == JAL;
  endfunction

  // Number of cycles from IF through the PC-update cycle; halt never retires.
  function automatic int path_len(input logic [5:0] op);
    case (cls_of(op))
      C_JMP:   return 2;
      C_BR:    return 3;
      C_SW:    return 4;
      C_R:     return 4;
      C_I:     return 4;
      C_LW:    return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] path_state(input logic [5:0] op, input int k);
    logic [2:0] seq[5];
    case (cls_of(op))
      C_BR:        seq = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd0};
      C_SW, C_LW:  seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      C_R, C_I:    seq = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd0};
      default:     seq = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    endcase
    return seq[(k > 4) ? 4 : k];
  endfunction

  function automatic logic [W-1:0] model(input logic rst, input logic [5:0] op,
                                         input int k, input logic z);
    int         c;
    logic       last, pcwre, irwre, regwre, wrsrc, mrd, mwr;
    logic       srca, srcb, ext, dbs;
    logic [1:0] pcsrc, regdst;
    logic [2:0] st, aluop;
    c      = cls_of(op);
    last   = !rst && path_len(op) != 0 && k == path_len(op) - 1;
    st     = rst ? 3'd0 : path_state(op, k);
    pcwre  = last;
    irwre  = !rst && k == 0;
    pcsrc  = 2'b00;
    if (last) begin
      if (op == J || op == JAL) pcsrc = 2'b11;
      else if (op == JR)        pcsrc = 2'b10;
      else if (op == BEQ)       pcsrc = z ? 2'b01 : 2'b00;
    end
    regwre = (last && (c == C_LW || c == C_R || c == C_I)) || (!rst && op == JAL && k == 1);
    regdst = 2'b00;
    if (regwre) regdst = (c == C_R) ? 2'b10 : (op == JAL) ? 2'b00 : 2'b01;
    wrsrc  = regwre && op != JAL;
    mrd    = !rst && op == LW && k == 3;
    mwr    = !rst && op == SW && k == 3;
    case (op)
      SUB, BEQ: aluop = 3'b001;
      SLL:      aluop = 3'b010;
      OR_, ORI: aluop = 3'b011;
      AND_:     aluop = 3'b100;
      SLT:      aluop = 3'b101;
      default:  aluop = 3'b000;
    endcase
    srca = (op == SLL);
    srcb = (op == ADDI || op == ORI || op == LW || op == SW);
    ext  = (op != ORI);
    dbs  = (op == LW);
    return {st, pcwre, pcsrc, irwre, regwre, regdst, wrsrc, mrd, mwr, aluop, srca, srcb, ext, dbs};
  endfunction

  // Compare process: one expected vector per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, mRD, mWR,
           ALUOp, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t op=%b rst=%b zero=%b got=%b expected=%b",
                 $time, opcode, reset, zero, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns at the following falling edge.
  task automatic drive_cycle(input logic rst, input logic [5:0] op, input int k, input int zf);
    reset  = rst;
    opcode = op;
    zero   = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    exp_q.push_back(model(rst, op, k, zero));
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic [5:0] op);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b1, op, 0, -1);
      nxt();
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int abort_at);
    int len;
    len = path_len(op);
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        do_reset(2, op);
        return;
      end
      drive_cycle(1'b0, op, k, -1);
      nxt();
    end
  endtask

  task automatic run_halt(input int n);
    for (int k = 0; k <= n; k++) begin
      drive_cycle(1'b0, HALT, k, -1);
      if (k < n) nxt();
    end
    chk("halt_state", state, 8'd1);
    chk("halt_pcwre", PCWre, 8'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", state, 8'd0);
    chk("async_reset_pcwre", PCWre, 8'd0);
    chk("async_reset_irwre", IRWre, 8'd0);
    nxt();
    do_reset(1, ADD);
  endtask

  logic [5:0] ops[14] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SW, LW, BEQ, J, JR, JAL};

  initial begin
    logic [5:0] op;
    int         ab, len;
    nxt();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, ADD, 0, -1);
      chk("reset_state", state, 8'd0);
      chk("reset_irwre", IRWre, 8'd0);
      nxt();
    end

    // add: IF loads IR on the first cycle after release, retires in WB_AL
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, ADD, k, -1);
      if (k == 0) chk("add_first_irwre", IRWre, 8'd1);
      if (k == 3) begin
        chk("add_wb_state", state, 8'h7);
        chk("add_wb_regdst", RegDst, 8'd2);
        chk("add_wb_pcwre", PCWre, 8'd1);
      end
      nxt();
    end

    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, LW, k, -1);
      if (k == 3) chk("lw_mem_mrd", mRD, 8'd1);
      if (k == 4) begin
        chk("lw_wb_state", state, 8'd4);
        chk("lw_wb_dbdatasrc", DBDataSrc, 8'd1);
      end
      nxt();
    end

    for (int zv = 1; zv >= 0; zv--) begin
      for (int k = 0; k < 3; k++) begin
        drive_cycle(1'b0, BEQ, k, zv);
        if (k == 2) begin
          chk("beq_pcsrc", PCSrc, (zv == 1) ? 8'd1 : 8'd0);
          chk("beq_pcwre", PCWre, 8'd1);
        end
        nxt();
      end
    end

    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, JAL, k, -1);
      if (k == 1) begin
        chk("jal_pcsrc", PCSrc, 8'd3);
        chk("jal_regwre", RegWre, 8'd1);
      end
      nxt();
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, JR, k, -1);
      if (k == 1) chk("jr_pcsrc", PCSrc, 8'd2);
      nxt();
    end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, ORI, k, -1);
      if (k == 2) begin
        chk("ori_aluop", ALUOp, 8'd3);
        chk("ori_extsel", ExtSel, 8'd0);
      end
      nxt();
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 6'b101010, k, -1);
      if (k == 1) chk("undef_pcwre", PCWre, 8'd1);
      nxt();
    end
    run_instr(ADD, 0);
    chk("after_undef_to_add_state", state, 8'd0);
    run_halt(20);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        run_halt($urandom_range(2, 8));
        continue;
      end
      if ($urandom_range(0, 16) < 14) op = ops[$urandom_range(0, 13)];
      else begin
        do op = 6'($urandom_range(0, 63)); while (is_def(op));
      end
      len = path_len(op);
      ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : -1;
      run_instr(op, ab);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
